// File: rtl/frame_scheduler.sv
// Per-frame draw sequencer: optional erase of the old footprint, y update, plot handshake, VGA write mux.
// Optional feature macro: FRAME_SCHEDULER_ERASE_EN (builds the ERASE state, its counters and drawn_y).
module frame_scheduler #(
  parameter logic [8:0]  X_POS    = 9'd10,
  parameter int unsigned SPRITE_W = 32,
  parameter int unsigned SPRITE_H = 64,
  parameter logic [7:0]  Y_MIN    = 8'd0,
  parameter logic [7:0]  Y_MAX    = 8'd176,
  parameter logic [7:0]  Y_INIT   = 8'd88,
  parameter logic [7:0]  STEP     = 8'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       sprite_done,
  input  logic [8:0] sprite_x,
  input  logic [7:0] sprite_y,
  input  logic [2:0] sprite_colour,
  input  logic       sprite_we,
  output logic       sprite_plot,
  output logic [7:0] sprite_y_in,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_we,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_UPDATE, S_PLOT, S_WAIT} state_t;

  state_t     state, state_nxt;
  logic [7:0] y, y_nxt;
  logic [8:0] y_plus, y_floor;
  logic       up_q, down_q;
  logic       erase_go;

`ifdef FRAME_SCHEDULER_ERASE_EN
  localparam int unsigned XW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned YW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  logic [XW-1:0] xcnt;
  logic [YW-1:0] ycnt;
  logic [7:0]    drawn_y;
  logic          drawn_valid;
  logic          x_last, erase_last;

  assign x_last     = (xcnt == XW'(SPRITE_W - 1));
  assign erase_last = x_last && (ycnt == YW'(SPRITE_H - 1));
  assign erase_go   = drawn_valid;
`else
  assign erase_go   = 1'b0;
`endif

  assign sprite_y_in = y;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and the clamped y update (y+STEP held at 9 bits so it cannot wrap)
  always_comb begin
    state_nxt = state;
    y_plus    = {1'b0, y} + {1'b0, STEP};
    y_floor   = {1'b0, Y_MIN} + {1'b0, STEP};
    y_nxt     = y;
    if (up_q && !down_q)
      y_nxt = ({1'b0, y} < y_floor) ? Y_MIN : (y - STEP);
    else if (down_q && !up_q)
      y_nxt = (y_plus > {1'b0, Y_MAX}) ? Y_MAX : y_plus[7:0];
    case (state)
      S_IDLE:   if (frame_tick) state_nxt = erase_go ? S_ERASE : S_UPDATE;
`ifdef FRAME_SCHEDULER_ERASE_EN
      S_ERASE:  if (erase_last) state_nxt = S_UPDATE;
`endif
      S_UPDATE: state_nxt = S_PLOT;
      S_PLOT:   state_nxt = S_WAIT;
      S_WAIT:   if (sprite_done) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      y           <= Y_INIT;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      sprite_plot <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      vga_x       <= 9'd0;
      vga_y       <= 8'd0;
      vga_colour  <= 3'd0;
      vga_we      <= 1'b0;
`ifdef FRAME_SCHEDULER_ERASE_EN
      xcnt        <= '0;
      ycnt        <= '0;
      drawn_y     <= 8'd0;
      drawn_valid <= 1'b0;
`endif
    end else begin
      sprite_plot <= (state == S_UPDATE);
      busy        <= (state_nxt != S_IDLE);
      vga_we      <= 1'b0;
      if (frame_tick && (state != S_IDLE)) overrun <= 1'b1;
      if (frame_tick && (state == S_IDLE)) begin
        up_q   <= move_up;
        down_q <= move_down;
      end
      if (state == S_UPDATE) y <= y_nxt;
      if (state == S_WAIT) begin
        vga_x      <= sprite_x;
        vga_y      <= sprite_y;
        vga_colour <= sprite_colour;
        vga_we     <= sprite_we;
      end
`ifdef FRAME_SCHEDULER_ERASE_EN
      if (state == S_ERASE) begin
        vga_x      <= X_POS + 9'(xcnt);
        vga_y      <= drawn_y + 8'(ycnt);
        vga_colour <= 3'b000;
        vga_we     <= 1'b1;
        xcnt       <= x_last ? '0 : xcnt + XW'(1);
        if (x_last) ycnt <= erase_last ? '0 : ycnt + YW'(1);
      end
      if (state == S_PLOT) begin
        drawn_y     <= y;
        drawn_valid <= 1'b1;
      end
`endif
    end
  end

endmodule
